// File: rtl/ex_div_pkg.sv
// Shared constants for the execute-stage divider: state encodings and control levels.
// DIV_SHORT is only reachable when DIV_EARLY_OUT_EN is defined.
package ex_div_pkg;

   typedef enum logic [2:0] {
      DIV_FREE   = 3'd0,
      DIV_BYZERO = 3'd1,
      DIV_ON     = 3'd2,
      DIV_END    = 3'd3,
      DIV_SHORT  = 3'd4
   } div_state_t;

   localparam logic        DIV_RESULT_READY     = 1'b1;
   localparam logic        DIV_RESULT_NOT_READY = 1'b0;
   localparam logic        DIV_START            = 1'b1;
   localparam logic        DIV_STOP             = 1'b0;
   localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;
   localparam logic        RST_ENABLE           = 1'b1;

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider (DIV/DIVU) returning {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to finish in one step when |dividend| < |divisor|.
module ex_div
   import ex_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o
);

   localparam logic [2*WIDTH-1:0] ZERO_RESULT = {WIDTH'(ZERO_WORD), WIDTH'(ZERO_WORD)};
   localparam logic [CNT_W-1:0]   LAST_CNT    = CNT_W'(WIDTH);

   // Two's complement negate when en is set; used for both magnitude and sign fix-up.
   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

   div_state_t            state_reg, state_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic [2*WIDTH:0]      dividend_reg, dividend_next;
   logic [WIDTH-1:0]      divisor_reg, divisor_next;
   logic                  neg_quo_reg, neg_quo_next;
   logic                  neg_rem_reg, neg_rem_next;
   logic [2*WIDTH-1:0]    result_reg, result_next;
   logic                  ready_reg, ready_next;

   logic [WIDTH-1:0]      mag_a, mag_b;
   logic                  sub_ok;
   logic [WIDTH-1:0]      diff;
   logic [WIDTH-1:0]      quo_fixed, rem_fixed;

   assign mag_a = neg_if(opdata1_i, signed_div_i & opdata1_i[WIDTH-1]);
   assign mag_b = neg_if(opdata2_i, signed_div_i & opdata2_i[WIDTH-1]);

   // The comparand is W+1 bits wide so divisors above 2^(W-1) are handled; the
   // difference itself always fits in W bits because it is below the divisor.
   assign sub_ok = dividend_reg[2*WIDTH:WIDTH] >= {1'b0, divisor_reg};
   assign diff   = dividend_reg[2*WIDTH-1:WIDTH] - divisor_reg;

   assign quo_fixed = neg_if(dividend_reg[WIDTH-1:0], neg_quo_reg);
   assign rem_fixed = neg_if(dividend_reg[2*WIDTH:WIDTH+1], neg_rem_reg);

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_reg    <= DIV_FREE;
         cnt_reg      <= '0;
         dividend_reg <= '0;
         divisor_reg  <= '0;
         neg_quo_reg  <= 1'b0;
         neg_rem_reg  <= 1'b0;
         result_reg   <= ZERO_RESULT;
         ready_reg    <= DIV_RESULT_NOT_READY;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         dividend_reg <= dividend_next;
         divisor_reg  <= divisor_next;
         neg_quo_reg  <= neg_quo_next;
         neg_rem_reg  <= neg_rem_next;
         result_reg   <= result_next;
         ready_reg    <= ready_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      dividend_next = dividend_reg;
      divisor_next  = divisor_reg;
      neg_quo_next  = neg_quo_reg;
      neg_rem_next  = neg_rem_reg;
      result_next   = result_reg;
      ready_next    = ready_reg;

      case (state_reg)
         DIV_FREE: begin
            result_next = ZERO_RESULT;
            ready_next  = DIV_RESULT_NOT_READY;
            if (start_i == DIV_START && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_next = DIV_BYZERO;
`ifdef DIV_EARLY_OUT_EN
               end else if (mag_a < mag_b) begin
                  // Quotient is zero; keep the original dividend as the remainder.
                  state_next    = DIV_SHORT;
                  dividend_next = {{(WIDTH+1){1'b0}}, opdata1_i};
`endif
               end else begin
                  state_next    = DIV_ON;
                  cnt_next      = '0;
                  dividend_next = {{WIDTH{1'b0}}, mag_a, 1'b0};
                  divisor_next  = mag_b;
                  neg_quo_next  = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  neg_rem_next  = signed_div_i & opdata1_i[WIDTH-1];
               end
            end
         end

         DIV_BYZERO: begin
            if (annul_i) begin
               state_next = DIV_FREE;
            end else begin
               state_next  = DIV_END;
               result_next = ZERO_RESULT;
               ready_next  = DIV_RESULT_READY;
            end
         end

         DIV_ON: begin
            if (annul_i) begin
               state_next = DIV_FREE;
            end else if (cnt_reg != LAST_CNT) begin
               if (sub_ok)
                  dividend_next = {diff, dividend_reg[WIDTH-1:0], 1'b1};
               else
                  dividend_next = {dividend_reg[2*WIDTH-1:0], 1'b0};
               cnt_next = cnt_reg + 1'b1;
            end else begin
               state_next  = DIV_END;
               result_next = {rem_fixed, quo_fixed};
               ready_next  = DIV_RESULT_READY;
            end
         end

         DIV_END: begin
            if (start_i == DIV_STOP) begin
               state_next  = DIV_FREE;
               result_next = ZERO_RESULT;
               ready_next  = DIV_RESULT_NOT_READY;
            end
         end

`ifdef DIV_EARLY_OUT_EN
         DIV_SHORT: begin
            if (annul_i) begin
               state_next = DIV_FREE;
            end else begin
               state_next  = DIV_END;
               result_next = {dividend_reg[WIDTH-1:0], {WIDTH{1'b0}}};
               ready_next  = DIV_RESULT_READY;
            end
         end
`endif

         default: begin
            state_next  = DIV_FREE;
            result_next = ZERO_RESULT;
            ready_next  = DIV_RESULT_NOT_READY;
         end
      endcase
   end

   assign result_o = result_reg;
   assign ready_o  = ready_reg;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, multi-cycle corner sequences,
// and randomized divisions checked against an arithmetic reference model.
module tb_ex_div;

   localparam int SLOW = 34;   // posedges from E0 through E33 inclusive
   localparam int FAST = 2;    // E0 and E1
`ifdef DIV_EARLY_OUT_EN
   localparam int EARLY_LAT = FAST;
`else
   localparam int EARLY_LAT = SLOW;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   ex_div #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   typedef struct {
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp_res;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, C-style truncation; divide-by-zero yields 0.
   function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      if (b == 32'd0) return 64'd0;
      x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic int ref_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint x, y;
      if (b == 32'd0) return FAST;
      x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (x < 0) x = -x;
      if (y < 0) y = -y;
      return (x < y) ? EARLY_LAT : SLOW;
   endfunction

   // Issue one division starting at the next posedge, measure latency, check the held
   // result for `hold` extra cycles, then drop start and check the outputs clear.
   task automatic run_txn(input string name, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res,
                          input int exp_lat, input int hold);
      int lat;
      lat = 0;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         @(negedge clk);
         // operands may change after the accepting edge without effect
         opdata1_i = $urandom;
         opdata2_i = $urandom;
         if (ready_o === 1'b1) begin
            lat = n;
            break;
         end
      end
      $display("txn %s sgn=%0d a=%h b=%h result=%h latency=%0d", name, sgn, a, b, result_o, lat);
      chk({name, " latency"}, 64'(lat), 64'(exp_lat));
      chk({name, " result"}, result_o, exp_res);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         chk({name, " hold ready"}, 64'(ready_o), 64'd1);
         chk({name, " hold result"}, result_o, exp_res);
      end
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({name, " drop ready"}, 64'(ready_o), 64'd0);
      chk({name, " drop result"}, result_o, 64'd0);
   endtask

   task automatic expect_idle(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int n = 0; n < cycles; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (ready_o !== 1'b0 || result_o !== 64'd0) seen++;
      end
      chk({name, " idle cycles with output"}, 64'(seen), 64'd0);
   endtask

   initial begin
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;

      vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},                   SLOW};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD},    SLOW};
      vecs[2] = '{1'b1, 32'd5,          32'd0,        64'd0,                             FAST};
      vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,{32'h0, 32'h8000_0000},            SLOW};
      vecs[4] = '{1'b0, 32'd9,          32'd3,        {32'd0, 32'd3},                    SLOW};
      vecs[5] = '{1'b0, 32'd3,          32'd10,       {32'd3, 32'd0},                    EARLY_LAT};
      vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,{32'h7FFF_FFFE, 32'd1},            SLOW};
      vecs[7] = '{1'b1, 32'd7,          32'hFFFF_FFFE,{32'd1, 32'hFFFF_FFFD},            SLOW};
      vecs[8] = '{1'b1, 32'hFFFF_FFF9,  32'd10,       {32'hFFFF_FFF9, 32'd0},            EARLY_LAT};
      vecs[9] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0, 32'hFFFF_FFFF},            SLOW};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset ready", 64'(ready_o), 64'd0);
      chk("reset result", result_o, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++)
         run_txn($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                 vecs[i].exp_res, vecs[i].exp_lat, (i == 0) ? 3 : 0);

      // Abort mid-division: annul sampled at E10, nothing must come out afterwards.
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
      end
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      annul_i = 1'b0;
      $display("txn annul at E10 ready=%0d result=%h", ready_o, result_o);
      expect_idle("annul", 40);
      run_txn("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, SLOW, 0);

      // Annul during the divide-by-zero cycle.
      signed_div_i = 1'b1;
      opdata1_i    = 32'd5;
      opdata2_i    = 32'd0;
      start_i      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      annul_i = 1'b0;
      $display("txn annul byzero ready=%0d result=%h", ready_o, result_o);
      expect_idle("annul byzero", 5);

      // Synchronous reset in the middle of a division (sampled at E5).
      signed_div_i = 1'b1;
      opdata1_i    = 32'hFFFF_FF00;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      $display("txn reset at E5 ready=%0d result=%h", ready_o, result_o);
      chk("midreset ready", 64'(ready_o), 64'd0);
      chk("midreset result", result_o, 64'd0);
      rst     = 1'b0;
      start_i = 1'b0;
      expect_idle("after midreset", 40);

      // start held during accept but annul also high: must not be accepted.
      signed_div_i = 1'b0;
      opdata1_i    = 32'd50;
      opdata2_i    = 32'd5;
      start_i      = 1'b1;
      annul_i      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      annul_i = 1'b0;
      expect_idle("start with annul", 40);

      for (int k = 0; k < 150; k++) begin
         bit          sgn;
         logic [31:0] a, b;
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            3: b = a + 32'($urandom_range(0, 3));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         run_txn($sformatf("rand%0d", k), sgn, a, b, ref_div(sgn, a, b),
                 ref_lat(sgn, a, b), k % 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
